reservation_station: RTL

// - Buffers ALU-class instrs (LUI/AUIPC/JAL/JALR/branch/OP-IMM/OP) from the decoder until both source operands are known.
// - Captures operands from the ALU and LSB result broadcasts (CDB); issues one ready instr per cycle to the ALU.
// - Sits directly downstream of the decoder, upstream of the ALU; cleared on ROB rollback.

---
 rtl/reservation_station_pkg.sv | 61 ++++++
 rtl/reservation_station_if.sv | 40 ++++
 rtl/reservation_station_picker.sv | 21 ++
 rtl/reservation_station.sv | 132 +++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: widths, opcode enum,
// entry layout and the CDB operand-capture helper.
package reservation_station_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned RS_SIZE   = 16;
  localparam int unsigned RS_IDX_W  = $clog2(RS_SIZE);
  localparam int unsigned RS_CNT_W  = RS_IDX_W + 1;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_TAG_W-1:0] rob_pos_t;

  localparam rob_pos_t ZERO_ROB  = '0;
  localparam data_t    ZERO_WORD = '0;

  typedef enum logic [OP_W-1:0] {
    OPENUM_NOP, OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU, OPENUM_XOR,
    OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } openum_t;

  typedef struct packed {
    rob_pos_t q;
    data_t    v;
  } operand_t;

  typedef struct packed {
    logic            busy;
    logic [OP_W-1:0] op;
    data_t           v1;
    data_t           v2;
    rob_pos_t        q1;
    rob_pos_t        q2;
    data_t           imm;
    data_t           pc;
    rob_pos_t        rob_tag;
  } rs_entry_t;

  // ALU broadcast checked before LSB; tags are unique so order never conflicts.
  function automatic operand_t cdb_capture(input operand_t op,
                                           input rob_pos_t alu_tag, input data_t alu_val,
                                           input rob_pos_t lsb_tag, input data_t lsb_val);
    operand_t r;
    r = op;
    if (r.q != ZERO_ROB && r.q == alu_tag) begin
      r.v = alu_val;
      r.q = ZERO_ROB;
    end
    if (r.q != ZERO_ROB && r.q == lsb_tag) begin
      r.v = lsb_val;
      r.q = ZERO_ROB;
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals between the reservation station
// and its neighbours.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic [ROB_TAG_W-1:0] in_dec_rob_tag;
  logic [OP_W-1:0]      in_dec_op;
  logic [DATA_W-1:0]    in_dec_value1;
  logic [DATA_W-1:0]    in_dec_value2;
  logic [ROB_TAG_W-1:0] in_dec_tag1;
  logic [ROB_TAG_W-1:0] in_dec_tag2;
  logic [DATA_W-1:0]    in_dec_imm;
  logic [DATA_W-1:0]    in_dec_pc;
  logic [ROB_TAG_W-1:0] in_alu_cdb_tag;
  logic [DATA_W-1:0]    in_alu_cdb_value;
  logic [ROB_TAG_W-1:0] in_lsb_cdb_tag;
  logic [DATA_W-1:0]    in_lsb_cdb_value;
  logic [ROB_TAG_W-1:0] out_alu_rob_tag;
  logic [OP_W-1:0]      out_alu_op;
  logic [DATA_W-1:0]    out_alu_value1;
  logic [DATA_W-1:0]    out_alu_value2;
  logic [DATA_W-1:0]    out_alu_imm;
  logic [DATA_W-1:0]    out_alu_pc;

  modport master (
    output in_dec_rob_tag, in_dec_op, in_dec_value1, in_dec_value2,
           in_dec_tag1, in_dec_tag2, in_dec_imm, in_dec_pc,
           in_alu_cdb_tag, in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value,
    input  out_alu_rob_tag, out_alu_op, out_alu_value1, out_alu_value2,
           out_alu_imm, out_alu_pc
  );

  modport slave (
    input  in_dec_rob_tag, in_dec_op, in_dec_value1, in_dec_value2,
           in_dec_tag1, in_dec_tag2, in_dec_imm, in_dec_pc,
           in_alu_cdb_tag, in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value,
    output out_alu_rob_tag, out_alu_op, out_alu_value1, out_alu_value2,
           out_alu_imm, out_alu_pc
  );
endinterface

// File: rtl/reservation_station_picker.sv
// Lowest-index priority picker: reports whether any request bit is set and
// the index of the lowest one.
module rs_lowest_picker #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (i_req[i-1]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i - 1);
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: holds dispatched instrs,
// snoops both CDBs for missing operands and issues one ready instr per cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_rollback,
  reservation_station_if.slave bus,
  output logic                 out_full
);
  rs_entry_t             r_ent [RS_SIZE];
  logic [RS_CNT_W-1:0]   r_count;
  logic [ROB_TAG_W-1:0]  r_out_tag;
  logic [OP_W-1:0]       r_out_op;
  data_t                 r_out_v1;
  data_t                 r_out_v2;
  data_t                 r_out_imm;
  data_t                 r_out_pc;

  logic [RS_SIZE-1:0]    w_free;
  logic [RS_SIZE-1:0]    w_ready;
  logic                  w_free_found;
  logic                  w_issue_found;
  logic [RS_IDX_W-1:0]   w_free_idx;
  logic [RS_IDX_W-1:0]   w_issue_idx;
  logic                  w_dispatch;
  operand_t              w_wake1 [RS_SIZE];
  operand_t              w_wake2 [RS_SIZE];
  operand_t              w_new1;
  operand_t              w_new2;

  always_comb begin
    w_free  = '0;
    w_ready = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      w_free[i]  = !r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && r_ent[i].q1 == ZERO_ROB && r_ent[i].q2 == ZERO_ROB;
      w_wake1[i] = cdb_capture('{q: r_ent[i].q1, v: r_ent[i].v1},
                               bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                               bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
      w_wake2[i] = cdb_capture('{q: r_ent[i].q2, v: r_ent[i].v2},
                               bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                               bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
    end
  end

  // Dispatched operands bypass from a same-cycle broadcast.
  always_comb begin
    w_new1 = cdb_capture('{q: bus.in_dec_tag1, v: bus.in_dec_value1},
                         bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                         bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
    w_new2 = cdb_capture('{q: bus.in_dec_tag2, v: bus.in_dec_value2},
                         bus.in_alu_cdb_tag, bus.in_alu_cdb_value,
                         bus.in_lsb_cdb_tag, bus.in_lsb_cdb_value);
  end

  rs_lowest_picker #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
    .i_req   (w_free),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_lowest_picker #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_pick (
    .i_req   (w_ready),
    .o_found (w_issue_found),
    .o_idx   (w_issue_idx)
  );

  assign w_dispatch = (bus.in_dec_rob_tag != ZERO_ROB) && w_free_found;
  assign out_full   = (r_count >= RS_CNT_W'(RS_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      r_count   <= '0;
      r_out_tag <= '0;
      r_out_op  <= '0;
      r_out_v1  <= '0;
      r_out_v2  <= '0;
      r_out_imm <= '0;
      r_out_pc  <= '0;
    end else if (rdy) begin
      if (in_rollback) begin
        for (int unsigned i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
        r_count   <= '0;
        r_out_tag <= ZERO_ROB;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (r_ent[i].busy) begin
            r_ent[i].q1 <= w_wake1[i].q;
            r_ent[i].v1 <= w_wake1[i].v;
            r_ent[i].q2 <= w_wake2[i].q;
            r_ent[i].v2 <= w_wake2[i].v;
          end
        end
        // Issue reads pre-edge state, so an entry woken this edge waits one cycle.
        if (w_issue_found) begin
          r_out_tag                 <= r_ent[w_issue_idx].rob_tag;
          r_out_op                  <= r_ent[w_issue_idx].op;
          r_out_v1                  <= r_ent[w_issue_idx].v1;
          r_out_v2                  <= r_ent[w_issue_idx].v2;
          r_out_imm                 <= r_ent[w_issue_idx].imm;
          r_out_pc                  <= r_ent[w_issue_idx].pc;
          r_ent[w_issue_idx].busy   <= 1'b0;
        end else begin
          r_out_tag <= ZERO_ROB;
        end
        if (w_dispatch) begin
          r_ent[w_free_idx] <= '{busy: 1'b1, op: bus.in_dec_op,
                                 v1: w_new1.v, v2: w_new2.v, q1: w_new1.q, q2: w_new2.q,
                                 imm: bus.in_dec_imm, pc: bus.in_dec_pc,
                                 rob_tag: bus.in_dec_rob_tag};
        end
        r_count <= r_count + RS_CNT_W'(w_dispatch) - RS_CNT_W'(w_issue_found);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !in_rollback && bus.in_dec_rob_tag != ZERO_ROB)
      assert (w_free_found);
  end

  assign bus.out_alu_rob_tag = r_out_tag;
  assign bus.out_alu_op      = r_out_op;
  assign bus.out_alu_value1  = r_out_v1;
  assign bus.out_alu_value2  = r_out_v2;
  assign bus.out_alu_imm     = r_out_imm;
  assign bus.out_alu_pc      = r_out_pc;
endmodule
